// File: rtl/hazard_scoreboard.sv
// ID-stage register hazard unit: per-register countdown until a result is forwardable.
// stall is combinational from ID inputs and the current counters; pending_mask and stall_count are registered.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic                id_flush,
    input  logic [ADDR_W-1:0]   id_rs1,
    input  logic [ADDR_W-1:0]   id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [ADDR_W-1:0]   id_rd,
    input  logic                id_reg_write,
    input  logic [1:0]          id_class,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [31:0]         stall_count
);

    localparam int MAX_AL  = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
    localparam int MAX_LAT = (MAX_AL > MUL_LAT) ? MAX_AL : MUL_LAT;
    localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending_mask_q, pending_mask_d;
    logic [31:0]         stall_count_q, stall_count_d;

    logic [CNT_W-1:0] lat;
    logic             raw1, raw2, waw, issue, wr_en;

    always_comb begin
        lat = CNT_W'(MUL_LAT);
        case (id_class)
            2'b00:   lat = CNT_W'(ALU_LAT);
            2'b01:   lat = CNT_W'(LOAD_LAT);
            default: lat = CNT_W'(MUL_LAT);
        endcase
    end

    always_comb begin
        raw1  = id_use_rs1 && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
        raw2  = id_use_rs2 && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
        // An older write still outstanding after this one would land must not overwrite it.
        waw   = id_reg_write && (id_rd != '0) && (cnt_q[id_rd] > lat);
        stall = id_valid && !id_flush && (raw1 || raw2 || waw);
        issue = id_valid && !id_flush && !stall;
        wr_en = issue && id_reg_write && (id_rd != '0);
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
            if (wr_en && (id_rd == ADDR_W'(r))) begin
                cnt_d[r] = lat;
            end
        end
        cnt_d[0] = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_mask_d[r] = (cnt_d[r] != '0);
        end
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            pending_mask_q <= '0;
            stall_count_q  <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            pending_mask_q <= pending_mask_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign pending_mask = pending_mask_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the model tracks, per register, the cycle at which its value becomes forwardable.
module tb_hazard_scoreboard;

    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          id_valid = 1'b0, id_flush = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_reg_write = 1'b0;
    logic [1:0]    id_class = '0;
    logic          stall;
    logic [NR-1:0] pending_mask;
    logic [31:0]   stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(NR), .ADDR_W(5), .ALU_LAT(0), .LOAD_LAT(1), .MUL_LAT(3)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_class(id_class),
        .stall(stall), .pending_mask(pending_mask), .stall_count(stall_count)
    );

    typedef struct {
        logic       v, f, u1, u2, rw;
        logic [4:0] rs1, rs2, rd;
        logic [1:0] cls;
    } instr_t;

    typedef struct {
        logic          stall;
        logic [NR-1:0] mask;
        longint        count;
    } exp_t;

    exp_t   q[$];
    longint ready [NR];   // cycle number at which register r is forwardable
    longint cyc = 0;
    longint exp_count = 0;
    int     total = 0, bad = 0;
    bit     mon_en = 1'b0;

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic instr_t mk(input logic v, f, u1, u2, rw, input logic [4:0] rs1, rs2, rd,
                                  input logic [1:0] cls);
        instr_t i;
        i.v = v; i.f = f; i.u1 = u1; i.u2 = u2; i.rw = rw;
        i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.cls = cls;
        return i;
    endfunction

    function automatic int lat_of(input logic [1:0] cls);
        return (cls == 2'd0) ? 0 : (cls == 2'd1) ? 1 : 3;
    endfunction

    task automatic drive(input instr_t in, output bit st);
        exp_t e;
        bit   raw1, raw2, waw;
        int   lat;
        @(posedge clk); #1;
        id_valid = in.v; id_flush = in.f; id_use_rs1 = in.u1; id_use_rs2 = in.u2;
        id_reg_write = in.rw; id_rs1 = in.rs1; id_rs2 = in.rs2; id_rd = in.rd; id_class = in.cls;
        lat  = lat_of(in.cls);
        raw1 = in.u1 && in.rs1 != 0 && ready[in.rs1] > cyc;
        raw2 = in.u2 && in.rs2 != 0 && ready[in.rs2] > cyc;
        waw  = in.rw && in.rd != 0 && (ready[in.rd] - cyc) > lat;
        st   = in.v && !in.f && (raw1 || raw2 || waw);
        if (in.v && !in.f && !st && in.rw && in.rd != 0) ready[in.rd] = cyc + 1 + lat;
        if (st) exp_count++;
        e.stall = st;
        for (int r = 0; r < NR; r++) e.mask[r] = (ready[r] > cyc + 1);
        e.count = exp_count;
        q.push_back(e);
        cyc++;
    endtask

    task automatic send(input instr_t in);
        bit st;
        for (int k = 0; k < 10; k++) begin
            drive(in, st);
            if (!st) break;
        end
    endtask

    function automatic instr_t rnd();
        return mk($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 8,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)));
    endfunction

    // Monitor: stall is checked mid-cycle, registered outputs just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && q.size() > 0) begin
                e = q.pop_front();
                chk("stall", longint'(stall), longint'(e.stall));
                @(posedge clk); #1;
                chk("pending_mask", longint'(pending_mask), longint'(e.mask));
                chk("stall_count", longint'(stall_count), e.count);
            end
        end
    end

    initial begin
        instr_t idle, cur;
        bit     st;
        int     budget;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < NR; r++) ready[r] = 0;
        #12;
        chk("reset_mask", longint'(pending_mask), 0);
        chk("reset_count", longint'(stall_count), 0);
        chk("reset_stall", longint'(stall), 0);
        #5 reset = 1'b1;
        mon_en = 1'b1;

        send(mk(1, 0, 0, 0, 1, 0, 0, 5, 2'd1));   // LOAD x5
        send(mk(1, 0, 1, 0, 1, 5, 0, 6, 2'd0));   // ALU uses x5
        send(mk(1, 0, 0, 0, 1, 0, 0, 7, 2'd2));   // MUL x7
        send(mk(1, 0, 0, 1, 1, 0, 7, 8, 2'd0));   // ADD uses x7
        send(mk(1, 0, 0, 0, 1, 0, 0, 9, 2'd2));   // MUL x9
        send(mk(1, 0, 0, 0, 1, 0, 0, 9, 2'd0));   // ALU writes x9 (WAW)
        send(mk(1, 0, 0, 0, 1, 0, 0, 0, 2'd1));   // LOAD x0
        send(mk(1, 0, 1, 1, 1, 0, 0, 1, 2'd0));   // uses x0
        send(mk(1, 0, 0, 0, 1, 0, 0, 6, 2'd1));   // LOAD x6
        send(mk(1, 0, 0, 0, 0, 6, 0, 0, 2'd0));   // rs1 = x6 but unused
        send(mk(1, 0, 0, 0, 1, 0, 0, 3, 2'd1));   // LOAD x3
        drive(mk(1, 1, 1, 0, 1, 3, 0, 2, 2'd2), st); // flushed dependent
        send(mk(1, 0, 0, 0, 1, 0, 0, 0, 2'd3));   // reserved class, rd = x0
        send(mk(1, 0, 1, 1, 1, 3, 3, 3, 2'd3));   // duplicate sources

        st = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!(st && $urandom_range(0, 9) < 8)) cur = rnd();
            drive(cur, st);
        end

        send(mk(1, 0, 0, 0, 1, 0, 0, 4, 2'd2));   // MUL x4
        drive(idle, st);
        @(posedge clk); #3;
        mon_en = 1'b0;
        chk("pre_reset_pend4", longint'(pending_mask[4]), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_mask", longint'(pending_mask), 0);
        chk("async_reset_count", longint'(stall_count), 0);
        #2 reset = 1'b1;
        for (int r = 0; r < NR; r++) ready[r] = 0;
        exp_count = 0;
        q.delete();
        mon_en = 1'b1;
        send(mk(1, 0, 1, 0, 1, 4, 0, 10, 2'd0));  // dependent on x4 after reset
        drive(idle, st);

        budget = 0;
        while (q.size() > 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: queue still holds %0d entries, required 0", q.size());
        end
        @(posedge clk); #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
